// File: rtl/ysyx_23060208_ifu_prefetch.sv
// Instruction prefetch unit: credit-limited AXI-lite style read issue, in-order
// PC tagging, an instruction FIFO toward the decoder, redirect flush and fault halt.
module ysyx_23060208_ifu_prefetch #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              redirect_valid,
  input  logic [DATA_WIDTH-1:0]             redirect_pc,
  output logic [DATA_WIDTH-1:0]             isram_araddr,
  output logic                              isram_arvalid,
  input  logic                              isram_arready,
  input  logic [DATA_WIDTH-1:0]             isram_rdata,
  input  logic [1:0]                        isram_rresp,
  input  logic                              isram_rvalid,
  output logic                              isram_rready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_pc,
  output logic [DATA_WIDTH-1:0]             out_inst,
  output logic                              out_fault,
  output logic [$clog2(MAX_OUTST+1)-1:0]    outst_cnt
);

  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int TAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_WAIT_AR = 2'd1;
  localparam logic [1:0] ST_HALT    = 2'd2;

  localparam logic [OW-1:0]         OUTST_ONE = OW'(1);
  localparam logic [FAW:0]          PTR_ONE   = (FAW + 1)'(1);
  localparam logic [TAW-1:0]        TAG_ONE   = TAW'(1);
  localparam logic [TAW-1:0]        TAG_LAST  = TAW'(MAX_OUTST - 1);
  localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(4);

  logic [1:0]            state_reg, state_next;
  logic [DATA_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [DATA_WIDTH-1:0] ar_addr_reg;
  logic                  ar_hold_reg, ar_hold_next;
  logic                  ar_stale_reg, ar_stale_next;
  logic [OW-1:0]         outst_reg, outst_next;
  logic [OW-1:0]         drop_reg, drop_next;
  logic [TAW-1:0]        tag_wr_reg, tag_wr_next;
  logic [TAW-1:0]        tag_rd_reg, tag_rd_next;
  logic [FAW:0]          fifo_wr_reg, fifo_wr_next;
  logic [FAW:0]          fifo_rd_reg, fifo_rd_next;

  logic [DATA_WIDTH-1:0] tag_mem       [MAX_OUTST];
  logic [DATA_WIDTH-1:0] fifo_pc_mem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_inst_mem [FIFO_DEPTH];
  logic                  fifo_fault_mem[FIFO_DEPTH];

  logic [FAW:0] fifo_count;
  logic         fifo_empty, fifo_full;
  logic         credit_ok;
  logic         ar_hs, ar_pend, r_hs;
  logic         drop_now, fault_now;
  logic         fifo_push, fifo_pop;

  function automatic logic [TAW-1:0] tag_inc(input logic [TAW-1:0] p);
    return (p == TAG_LAST) ? '0 : p + TAG_ONE;
  endfunction

  assign fifo_count = fifo_wr_reg - fifo_rd_reg;
  assign fifo_empty = (fifo_wr_reg == fifo_rd_reg);
  assign fifo_full  = (fifo_wr_reg[FAW] != fifo_rd_reg[FAW]) &&
                      (fifo_wr_reg[FAW-1:0] == fifo_rd_reg[FAW-1:0]);

  // Every outstanding read already owns a FIFO slot, so responses never overflow.
  assign credit_ok = ((int'(outst_reg) + int'(fifo_count)) < FIFO_DEPTH) &&
                     (int'(outst_reg) < MAX_OUTST);

  assign isram_arvalid = !rst && (ar_hold_reg || ((state_reg == ST_FETCH) && credit_ok));
  assign isram_araddr  = ar_hold_reg ? ar_addr_reg :
                         (isram_arvalid ? fetch_pc_reg : '0);
  assign isram_rready  = !rst && (outst_reg != '0);

  assign ar_hs   = isram_arvalid && isram_arready;
  assign ar_pend = isram_arvalid && !isram_arready;
  assign r_hs    = isram_rvalid && isram_rready;

  assign drop_now  = redirect_valid || (drop_reg != '0);
  assign fault_now = r_hs && !drop_now && (isram_rresp != 2'b00);
  assign fifo_push = r_hs && !drop_now && (!fifo_full || fifo_pop);
  assign fifo_pop  = !fifo_empty && out_ready;

  assign out_valid = !fifo_empty;
  assign out_pc    = out_valid ? fifo_pc_mem[fifo_rd_reg[FAW-1:0]]    : '0;
  assign out_inst  = out_valid ? fifo_inst_mem[fifo_rd_reg[FAW-1:0]]  : '0;
  assign out_fault = out_valid ? fifo_fault_mem[fifo_rd_reg[FAW-1:0]] : 1'b0;
  assign outst_cnt = outst_reg;

  always_comb begin
    outst_next = outst_reg;
    if (ar_hs && !r_hs) begin
      outst_next = outst_reg + OUTST_ONE;
    end else if (!ar_hs && r_hs) begin
      outst_next = outst_reg - OUTST_ONE;
    end
  end

  // A request still waiting for arready at redirect time targets the old path.
  always_comb begin
    ar_hold_next  = ar_pend;
    ar_stale_next = ar_pend && (redirect_valid || ar_stale_reg);
    fetch_pc_next = fetch_pc_reg;
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc;
    end else if (ar_hs && !ar_stale_reg) begin
      fetch_pc_next = fetch_pc_reg + PC_STEP;
    end
  end

  always_comb begin
    drop_next = drop_reg;
    if (redirect_valid) begin
      drop_next = outst_next + OW'(ar_pend);
    end else if (r_hs && (drop_reg != '0)) begin
      drop_next = drop_reg - OUTST_ONE;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (redirect_valid) begin
      state_next = ar_hold_next ? ST_WAIT_AR : ST_FETCH;
    end else if (fault_now || (state_reg == ST_HALT)) begin
      state_next = ST_HALT;
    end else begin
      state_next = ar_hold_next ? ST_WAIT_AR : ST_FETCH;
    end
  end

  always_comb begin
    tag_wr_next  = tag_wr_reg;
    tag_rd_next  = tag_rd_reg;
    fifo_wr_next = fifo_wr_reg;
    fifo_rd_next = fifo_rd_reg;
    if (ar_hs) tag_wr_next = tag_inc(tag_wr_reg);
    if (r_hs)  tag_rd_next = tag_inc(tag_rd_reg);
    if (redirect_valid) begin
      fifo_wr_next = '0;
      fifo_rd_next = '0;
    end else begin
      if (fifo_push) fifo_wr_next = fifo_wr_reg + PTR_ONE;
      if (fifo_pop)  fifo_rd_next = fifo_rd_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_FETCH;
      fetch_pc_reg <= RESET_PC;
      ar_addr_reg  <= '0;
      ar_hold_reg  <= 1'b0;
      ar_stale_reg <= 1'b0;
      outst_reg    <= '0;
      drop_reg     <= '0;
      tag_wr_reg   <= '0;
      tag_rd_reg   <= '0;
      fifo_wr_reg  <= '0;
      fifo_rd_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if (ar_pend) ar_addr_reg <= isram_araddr;
      ar_hold_reg  <= ar_hold_next;
      ar_stale_reg <= ar_stale_next;
      outst_reg    <= outst_next;
      drop_reg     <= drop_next;
      tag_wr_reg   <= tag_wr_next;
      tag_rd_reg   <= tag_rd_next;
      fifo_wr_reg  <= fifo_wr_next;
      fifo_rd_reg  <= fifo_rd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      tag_mem[tag_wr_reg] <= isram_araddr;
    end
    if (fifo_push) begin
      fifo_pc_mem[fifo_wr_reg[FAW-1:0]]    <= tag_mem[tag_rd_reg];
      fifo_inst_mem[fifo_wr_reg[FAW-1:0]]  <= isram_rdata;
      fifo_fault_mem[fifo_wr_reg[FAW-1:0]] <= (isram_rresp != 2'b00);
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_ifu_prefetch.sv
// Directed bench for the prefetch unit with an in-order, one-cycle read slave whose
// instruction word is address + 0x1000_0000 and which can fault one chosen address.
module tb_ysyx_23060208_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] isram_araddr;
  logic        isram_arvalid;
  logic        isram_arready = 1'b0;
  logic [31:0] isram_rdata;
  logic [1:0]  isram_rresp;
  logic        isram_rvalid;
  logic        isram_rready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic [1:0]  outst_cnt;

  logic        r_en = 1'b0;
  logic        fault_en = 1'b0;
  logic [31:0] fault_addr = '0;
  logic [31:0] sq_addr [0:15];
  logic [4:0]  sq_head, sq_tail;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ysyx_23060208_ifu_prefetch dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .isram_araddr(isram_araddr), .isram_arvalid(isram_arvalid), .isram_arready(isram_arready),
    .isram_rdata(isram_rdata), .isram_rresp(isram_rresp), .isram_rvalid(isram_rvalid),
    .isram_rready(isram_rready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_fault(out_fault), .outst_cnt(outst_cnt)
  );

  // In-order slave: a request accepted at one edge is answered from the next cycle.
  assign isram_rvalid = r_en && (sq_head != sq_tail);
  assign isram_rdata  = sq_addr[sq_head[3:0]] + 32'h1000_0000;
  assign isram_rresp  = (fault_en && (sq_addr[sq_head[3:0]] == fault_addr)) ? 2'd2 : 2'd0;

  always @(posedge clk) begin
    if (rst) begin
      sq_head <= '0;
      sq_tail <= '0;
    end else begin
      if (isram_rvalid && isram_rready) sq_head <= sq_head + 5'd1;
      if (isram_arvalid && isram_arready) begin
        sq_addr[sq_tail[3:0]] <= isram_araddr;
        sq_tail <= sq_tail + 5'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    isram_arready = 1'b0;
    r_en = 1'b0;
    out_ready = 1'b0;
    fault_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({isram_arvalid, isram_rready, out_valid, out_fault, outst_cnt} !== 6'b0)
      $display("FAIL reset_ctrl: got arvalid=%b rready=%b out_valid=%b fault=%b outst=%0d, expected all 0",
               isram_arvalid, isram_rready, out_valid, out_fault, outst_cnt);
    else passes++;
    checks++;
    if ({isram_araddr, out_pc, out_inst} !== 96'h0)
      $display("FAIL reset_data: got araddr=%h out_pc=%h out_inst=%h, expected 0", isram_araddr, out_pc, out_inst);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if ({isram_arvalid, isram_araddr} !== {1'b1, 32'h8000_0000})
      $display("FAIL first_ar: got arvalid=%b araddr=%h, expected 1 80000000", isram_arvalid, isram_araddr);
    else passes++;
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc = 32'h8000_0000;
    int npop = 0;
    do_reset();
    isram_arready = 1'b1; r_en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        $display("stream pop pc=%h inst=%h fault=%b", out_pc, out_inst, out_fault);
        checks++;
        if ({out_pc, out_inst, out_fault} !== {exp_pc, exp_pc + 32'h1000_0000, 1'b0})
          $display("FAIL stream_pop: got pc=%h inst=%h fault=%b, expected pc=%h inst=%h fault=0",
                   out_pc, out_inst, out_fault, exp_pc, exp_pc + 32'h1000_0000);
        else passes++;
        exp_pc = exp_pc + 32'd4;
        npop++;
      end
      if (k == 6) begin
        checks++;
        if (outst_cnt !== 2'd1) $display("FAIL stream_outst: got %0d expected 1", outst_cnt);
        else passes++;
      end
      tick();
    end
    checks++;
    if (npop !== 18) $display("FAIL stream_rate: got %0d pops expected 18", npop);
    else passes++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc = 32'h8000_0004;
    int n_ar = 0;
    int npop = 0;
    do_reset();
    isram_arready = 1'b1; r_en = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (isram_arvalid && isram_arready) n_ar++;
      tick();
    end
    checks++;
    if (n_ar !== 4) $display("FAIL bp_ar_count: got %0d handshakes expected 4", n_ar);
    else passes++;
    checks++;
    if ({isram_arvalid, out_valid, out_pc} !== {1'b0, 1'b1, 32'h8000_0000})
      $display("FAIL bp_hold: got arvalid=%b out_valid=%b out_pc=%h expected 0 1 80000000",
               isram_arvalid, out_valid, out_pc);
    else passes++;
    out_ready = 1'b1;
    tick();
    checks++;
    if ({isram_arvalid, isram_araddr} !== {1'b1, 32'h8000_0010})
      $display("FAIL bp_resume: got arvalid=%b araddr=%h expected 1 80000010", isram_arvalid, isram_araddr);
    else passes++;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) begin
        $display("bp pop pc=%h", out_pc);
        checks++;
        if (out_pc !== exp_pc) $display("FAIL bp_pop: got pc=%h expected %h", out_pc, exp_pc);
        else passes++;
        exp_pc = exp_pc + 32'd4;
        npop++;
      end
      tick();
    end
    checks++;
    if (npop !== 10) $display("FAIL bp_rate: got %0d pops expected 10", npop);
    else passes++;
  endtask

  task automatic test_ar_stall();
    int n_ar = 0;
    bit found = 0;
    do_reset();
    isram_arready = 1'b0; r_en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({isram_arvalid, isram_araddr} !== {1'b1, 32'h8000_0000})
        $display("FAIL stall_stable: cycle %0d got arvalid=%b araddr=%h expected 1 80000000",
                 k, isram_arvalid, isram_araddr);
      else passes++;
      tick();
    end
    isram_arready = 1'b1;
    if (isram_arvalid && isram_arready) n_ar++;
    tick();
    isram_arready = 1'b0;
    checks++;
    if ({isram_arvalid, isram_araddr, outst_cnt} !== {1'b1, 32'h8000_0004, 2'd1} || n_ar !== 1)
      $display("FAIL stall_single: got arvalid=%b araddr=%h outst=%0d hs=%0d expected 1 80000004 1 1",
               isram_arvalid, isram_araddr, outst_cnt, n_ar);
    else passes++;
    isram_arready = 1'b1;
    for (int k = 0; k < 10 && !found; k++) begin
      if (out_valid) begin
        found = 1;
        checks++;
        if (out_pc !== 32'h8000_0000) $display("FAIL stall_first_pop: got pc=%h expected 80000000", out_pc);
        else passes++;
      end
      tick();
    end
    checks++;
    if (found !== 1'b1) $display("FAIL stall_timeout: got no output expected one");
    else passes++;
  endtask

  task automatic test_redirect_outstanding();
    logic [31:0] exp_pc = 32'h8000_0100;
    int npop = 0;
    bit seen_ar = 0;
    do_reset();
    isram_arready = 1'b1; r_en = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({outst_cnt, isram_arvalid} !== {2'd2, 1'b0})
      $display("FAIL redir_pre: got outst=%0d arvalid=%b expected 2 0", outst_cnt, isram_arvalid);
    else passes++;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    r_en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (!seen_ar && isram_arvalid) begin
        seen_ar = 1;
        checks++;
        if (isram_araddr !== 32'h8000_0100) $display("FAIL redir_ar: got araddr=%h expected 80000100", isram_araddr);
        else passes++;
      end
      if (out_valid && npop < 3) begin
        $display("redirect pop pc=%h", out_pc);
        checks++;
        if (out_pc !== exp_pc) $display("FAIL redir_pop: got pc=%h expected %h", out_pc, exp_pc);
        else passes++;
        exp_pc = exp_pc + 32'd4;
        npop++;
      end
      tick();
    end
    checks++;
    if (npop !== 3) $display("FAIL redir_count: got %0d pops expected 3", npop);
    else passes++;
  endtask

  task automatic test_redirect_pending();
    bit found = 0;
    do_reset();
    isram_arready = 1'b0; r_en = 1'b1; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0180;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({isram_arvalid, isram_araddr} !== {1'b1, 32'h8000_0000})
      $display("FAIL pend_stale_held: got arvalid=%b araddr=%h expected 1 80000000", isram_arvalid, isram_araddr);
    else passes++;
    isram_arready = 1'b1;
    tick();
    checks++;
    if ({isram_arvalid, isram_araddr} !== {1'b1, 32'h8000_0180})
      $display("FAIL pend_new_ar: got arvalid=%b araddr=%h expected 1 80000180", isram_arvalid, isram_araddr);
    else passes++;
    for (int k = 0; k < 10 && !found; k++) begin
      if (out_valid) begin
        found = 1;
        checks++;
        if (out_pc !== 32'h8000_0180) $display("FAIL pend_first_pop: got pc=%h expected 80000180", out_pc);
        else passes++;
      end
      tick();
    end
    checks++;
    if (found !== 1'b1) $display("FAIL pend_timeout: got no output expected one");
    else passes++;
  endtask

  task automatic test_fault();
    logic [31:0] exp_pc = 32'h8000_0000;
    int npop = 0;
    int n_ar_after = 0;
    bit seen_fault = 0;
    do_reset();
    fault_en = 1'b1; fault_addr = 32'h8000_0008;
    isram_arready = 1'b1; r_en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (out_valid) begin
        $display("fault pop pc=%h fault=%b", out_pc, out_fault);
        checks++;
        if ({out_pc, out_inst, out_fault} !== {exp_pc, exp_pc + 32'h1000_0000, exp_pc == 32'h8000_0008})
          $display("FAIL fault_pop: got pc=%h inst=%h fault=%b expected pc=%h fault=%b",
                   out_pc, out_inst, out_fault, exp_pc, exp_pc == 32'h8000_0008);
        else passes++;
        if (out_fault) seen_fault = 1;
        exp_pc = exp_pc + 32'd4;
        npop++;
      end
      if (seen_fault && isram_arvalid) n_ar_after++;
      tick();
    end
    checks++;
    if ({npop, n_ar_after} !== {32'd4, 32'd0})
      $display("FAIL fault_halt: got pops=%0d ar_after=%0d expected 4 0", npop, n_ar_after);
    else passes++;
    fault_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({isram_arvalid, isram_araddr} !== {1'b1, 32'h8000_0200})
      $display("FAIL fault_exit: got arvalid=%b araddr=%h expected 1 80000200", isram_arvalid, isram_araddr);
    else passes++;
  endtask

  task automatic test_redirect_collide();
    bit found = 0;
    do_reset();
    isram_arready = 1'b1; r_en = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({out_valid, out_pc, isram_rready} !== {1'b1, 32'h8000_0004, 1'b1})
      $display("FAIL coll_pre: got out_valid=%b out_pc=%h rready=%b expected 1 80000004 1",
               out_valid, out_pc, isram_rready);
    else passes++;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({out_valid, outst_cnt} !== {1'b0, 2'd1})
      $display("FAIL coll_flush: got out_valid=%b outst=%0d expected 0 1", out_valid, outst_cnt);
    else passes++;
    checks++;
    if ({isram_arvalid, isram_araddr} !== {1'b1, 32'h8000_0300})
      $display("FAIL coll_ar: got arvalid=%b araddr=%h expected 1 80000300", isram_arvalid, isram_araddr);
    else passes++;
    for (int k = 0; k < 10 && !found; k++) begin
      if (out_valid) begin
        found = 1;
        checks++;
        if (out_pc !== 32'h8000_0300) $display("FAIL coll_first_pop: got pc=%h expected 80000300", out_pc);
        else passes++;
      end
      tick();
    end
    checks++;
    if (found !== 1'b1) $display("FAIL coll_timeout: got no output expected one");
    else passes++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_ar_stall();
    test_redirect_outstanding();
    test_redirect_pending();
    test_fault();
    test_redirect_collide();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
